// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures the ALU output, RESP holds it until taken.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [OPW-1:0]   op_code_reg;
  logic [WIDTH-1:0] res_reg;
  logic             zf_reg;
  logic             gnt_reg;
  logic             prio_reg;

  logic [1:0]       req_valid;
  logic [1:0]       resp_ready;
  logic [1:0]       resp_valid;
  logic             winner;
  logic             take;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  // On a tie the prio requester wins; otherwise whoever is valid (req1 only if it alone is).
  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) begin
      winner = prio_reg;
    end
  end

  assign take       = (state_reg == IDLE) && (|req_valid) && !reset;
  assign req0_ready = take && !winner;
  assign req1_ready = take && winner;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign resp_valid[gi] = (state_reg == RESP) && (gnt_reg == 1'(gi));
    end
  endgenerate

  assign resp0_valid  = resp_valid[0];
  assign resp1_valid  = resp_valid[1];
  assign resp0_result = res_reg;
  assign resp1_result = res_reg;
  assign resp0_zero   = zf_reg;
  assign resp1_zero   = zf_reg;

  assign alu_src_a   = op_a_reg;
  assign alu_src_b   = op_b_reg;
  assign alu_control = op_code_reg;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      op_code_reg <= '0;
      res_reg     <= '0;
      zf_reg      <= 1'b0;
      gnt_reg     <= 1'b0;
      prio_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            op_a_reg    <= winner ? req1_a  : req0_a;
            op_b_reg    <= winner ? req1_b  : req0_b;
            op_code_reg <= winner ? req1_op : req0_op;
            gnt_reg     <= winner;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          res_reg   <= alu_result;
          zf_reg    <= alu_zero;
          state_reg <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the transfer; the other side is ignored.
          if (resp_ready[gnt_reg]) begin
            prio_reg  <= ~gnt_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized operations checked against
// a transaction-level model (last-served prio, ALU result of the granted operands).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic [31:0] req0_a, req0_b, resp0_result;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [31:0] req1_a, req1_b, resp1_result;
  logic [3:0]  req1_op;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero, busy;

  int   total = 0;
  int   bad   = 0;
  logic prio_m;
  int   n_ops = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // External ALU stand-in
  assign alu_result = ref_alu(alu_src_a, alu_src_b, alu_control);
  assign alu_zero   = (alu_result == 32'h0);

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_resp0_valid"}, resp0_valid, 1'b0);
    check1({tag, "_resp1_valid"}, resp1_valid, 1'b0);
    check32({tag, "_src_a"}, alu_src_a, 32'h0);
    check32({tag, "_src_b"}, alu_src_b, 32'h0);
    check32({tag, "_ctrl"}, {28'h0, alu_control}, 32'h0);
    check32({tag, "_result"}, resp0_result, 32'h0);
    check1({tag, "_zero"}, resp0_zero, 1'b0);
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; resp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prio_m = 1'b0;
  endtask

  // One operation: IDLE accept cycle, EXEC cycle, then hold+1 RESP cycles; owner takes on the last.
  // Ends just after the completing edge has been set up; the next call's first negedge is IDLE.
  task automatic run_op(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] o0, input logic v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [3:0] o1, input int hold,
                        output logic g);
    logic        w;
    logic [31:0] ea, eb, er;
    logic [3:0]  eo;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    w  = (v0 && v1) ? prio_m : v1;
    g  = req1_ready;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? o1 : o0;
    er = ref_alu(ea, eb, eo);
    check1("idle_busy", busy, 1'b0);
    check1("idle_req0_ready", req0_ready, v0 && !w);
    check1("idle_req1_ready", req1_ready, v1 && w);
    check1("idle_resp0_valid", resp0_valid, 1'b0);
    check1("idle_resp1_valid", resp1_valid, 1'b0);

    @(negedge clk);
    if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    check1("exec_busy", busy, 1'b1);
    check1("exec_req0_ready", req0_ready, 1'b0);
    check1("exec_req1_ready", req1_ready, 1'b0);
    check1("exec_resp0_valid", resp0_valid, 1'b0);
    check1("exec_resp1_valid", resp1_valid, 1'b0);
    check32("exec_src_a", alu_src_a, ea);
    check32("exec_src_b", alu_src_b, eb);
    check32("exec_ctrl", {28'h0, alu_control}, {28'h0, eo});

    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      resp0_ready = w ? 1'($urandom_range(0, 1)) : (k == hold);
      resp1_ready = w ? (k == hold) : 1'($urandom_range(0, 1));
      #1;
      check1("resp_busy", busy, 1'b1);
      check1("resp_resp0_valid", resp0_valid, !w);
      check1("resp_resp1_valid", resp1_valid, w);
      check32("resp_result0", resp0_result, er);
      check32("resp_result1", resp1_result, er);
      check1("resp_zero0", resp0_zero, er == 32'h0);
      check1("resp_zero1", resp1_zero, er == 32'h0);
      check1("resp_req0_ready", req0_ready, 1'b0);
      check1("resp_req1_ready", req1_ready, 1'b0);
      check32("resp_src_a", alu_src_a, ea);
    end
    prio_m = ~w;
    n_ops++;
    $display("op %0d: gnt=%0d a=%h b=%h op=%h result=%h zero=%0d hold=%0d",
             n_ops, w, ea, eb, eo, er, er == 32'h0, hold);
  endtask

  initial begin
    logic        g;
    logic        v0, v1;
    logic [3:0]  ops [7];
    logic [31:0] ra0, rb0, ra1, rb1;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};

    clear_inputs();
    reset  = 1'b1;
    prio_m = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    check1("por_req0_ready", req0_ready, 1'b0);
    check1("por_req1_ready", req1_ready, 1'b0);
    reset = 1'b0;

    // Single req0 ADD, then busy must be low the cycle after completion
    run_op(1'b1, 32'd5, 32'd7, 4'b0010, 1'b0, 32'd0, 32'd0, 4'b0000, 0, g);
    @(negedge clk);
    clear_inputs();
    #1;
    check1("after_take_busy", busy, 1'b0);
    check32("add_result", resp0_result, 32'd12);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    run_op(1'b1, 32'd10, 32'd10, 4'b0110, 1'b1, 32'h0000F0F0, 32'h00000FF0, 4'b0000, 0, g);
    check1("tie_first_gnt", g, 1'b0);
    check32("sub_result", resp0_result, 32'h0);
    run_op(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'h0000F0F0, 32'h00000FF0, 4'b0000, 0, g);
    check1("tie_second_gnt", g, 1'b1);
    check32("and_result", resp1_result, 32'h000000F0);

    // Both hold valid continuously: grants alternate
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, 32'(i), 32'd3, 4'b0010, 1'b1, 32'(i * 7), 32'd1, 4'b0001, 0, g);
      check1("alt_gnt", g, 1'(i % 2));
    end

    // req1 stalled response while req0 keeps asking
    run_op(1'b1, 32'd1, 32'd2, 4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 0, g);
    run_op(1'b1, 32'd9, 32'd9, 4'b0010, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0010, 5, g);
    check1("stall_gnt", g, 1'b1);
    check32("wrap_result", resp1_result, 32'h0);
    check1("wrap_zero", resp1_zero, 1'b1);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      ra0 = $urandom(); rb0 = $urandom(); ra1 = $urandom(); rb1 = $urandom();
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      run_op(v0, ra0, rb0, ops[$urandom_range(0, 6)], v1, ra1, rb1, ops[$urandom_range(0, 6)],
             $urandom_range(0, 3), g);
    end

    // Reset during EXEC drops the operation
    @(negedge clk);
    clear_inputs();
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'b0010;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check1("mid_exec_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    prio_m = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check1("dropped_resp0_valid", resp0_valid, 1'b0);
      check1("dropped_busy", busy, 1'b0);
    end
    run_op(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd20, 32'd22, 4'b0110, 0, g);
    check1("post_reset_gnt", g, 1'b1);
    check32("post_reset_result", resp1_result, 32'hFFFFFFFE);

    @(negedge clk);
    clear_inputs();
    #1;
    check1("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: req 0 is the main datapath and req 1 is the address/branch unit.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Operands are registered, the ALU result is captured in a register, and the result is held until the owning requester accepts it.
- Sits between the requesters and the ALU; it drives the ALU src_a/src_b/alu_control inputs and samples result/zero.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, ALU control code width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_op  in  OPW  ALU control code
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 consumes result
- resp0_result  out  WIDTH  captured ALU result
- resp0_zero  out  1  captured ALU zero flag
- req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready, resp1_result, resp1_zero  same as requester 0, for requester 1
- alu_src_a  out  WIDTH  to ALU src_a
- alu_src_b  out  WIDTH  to ALU src_b
- alu_control  out  OPW  to ALU control
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  high whenever state != IDLE

Behaviour:
- All state changes occur on the rising clk edge. reset has priority over everything.
- Registers:
  - op_a, op_b, op_code: feed alu_src_a, alu_src_b, alu_control directly.
  - res, zf: captured result and zero flag.
  - gnt: id of the current owner.
  - prio: requester with priority on the next tie.
- State machine (IDLE, EXEC, RESP):
  - IDLE:
    - If any reqN_valid is high, select the winner. If only one is valid, that one wins; if both are valid, requester prio wins.
    - The winner's reqN_ready is high combinationally in that same cycle; the loser's is low.
    - At the edge: capture the winner's a/b/op into op_a/op_b/op_code, set gnt = winner, go to EXEC.
    - If no request is valid, stay in IDLE.
  - EXEC:
    - The ALU is evaluated from the registered operands.
    - At the edge: res <= alu_result, zf <= alu_zero, go to RESP.
  - RESP:
    - respN_valid is high for N == gnt only; respN_result = res and respN_zero = zf.
    - When resp[gnt]_ready is high at the edge: set prio <= ~gnt and go to IDLE.
    - Otherwise hold res, zf and valid unchanged.
- Ready rule: reqN_ready is low in EXEC and RESP. No new request is accepted until the response is consumed, so there is at most one operation in flight.
- Latency and throughput:
  - Request accepted at edge T; respN_valid is high from cycle T+2.
  - Minimum 3 cycles per operation, with resp_ready tied high.
- Ports of the non-owning requester:
  - respN_valid stays low.
  - respN_result and respN_zero still show res and zf (don't-care by protocol).
- ALU drive:
  - alu_src_a, alu_src_b and alu_control always equal the operand registers, including in IDLE and RESP. They are stable glitch-free registered values.
- Opcodes are passed through unchecked. Undefined codes return whatever the ALU produces (0 for unmapped codes).
- resp_ready asserted outside RESP, or by the non-owning requester, is ignored.
- A requester deasserting req_valid before it sees ready is legal; the request is simply not taken.
- Reset values (also on reset mid-operation):
  - State goes to IDLE; any in-flight operation is dropped with no response.
  - op_a = op_b = 0, op_code = 0, res = 0, zf = 0, gnt = 0, prio = 0.
  - All valid/ready outputs and busy = 0.

Test Plan:
- After reset, req0 ADD (op 0010) a=5, b=7 with resp0_ready held high.
  - req0_ready is high in the first cycle.
  - resp0_valid is high 2 cycles later with result 12, zero 0.
  - busy is low one cycle after the response is accepted.
- Both requests in the same cycle after reset: req0 SUB (0110) 10-10, req1 AND (0000) 0xF0F0 & 0x0FF0.
  - req0 is served first: result 0, zero 1.
  - req1 is then served: result 0x00F0, zero 0. req1_ready is first high in the cycle after resp0 is consumed.
- Both requesters hold valid continuously for 6 operations → grants alternate 0,1,0,1,0,1 and no requester wins twice in a row.
- req1 ADD 0xFFFFFFFF+1 with resp1_ready low for 5 cycles:
  - resp1_valid stays high with result 0 and zero 1 throughout.
  - req0_ready stays low throughout.
  - Completion occurs on the first cycle resp1_ready goes high.
- Assert reset during EXEC of a req0 operation:
  - Next cycle: state is IDLE and all outputs are at their reset values.
  - No resp0_valid ever appears for the dropped operation.
  - A fresh req1 is accepted immediately.
